// File: rtl/adc_conv_scheduler_pkg.sv
// Shared definitions for the ADC conversion scheduler and later ADC consumers:
// macro channel codes, scheduler FSM states and conversion slots.
package adc_conv_scheduler_pkg;

   localparam logic [2:0] CH_I   = 3'b110;
   localparam logic [2:0] CH_Q   = 3'b100;
   localparam logic [2:0] CH_MIC = 3'b011;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_STORE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      SLOT_I   = 2'd0,
      SLOT_Q   = 2'd1,
      SLOT_MIC = 2'd2
   } slot_t;

   function automatic logic [2:0] slot_to_ch(input slot_t slot);
      case (slot)
         SLOT_I:   slot_to_ch = CH_I;
         SLOT_Q:   slot_to_ch = CH_Q;
         SLOT_MIC: slot_to_ch = CH_MIC;
         default:  slot_to_ch = CH_I;
      endcase
   endfunction

endpackage

// File: rtl/adc_conv_scheduler_timeout_cnt.sv
// 8-bit clear/enable counter that saturates at TERM and flags it; used to
// bound handshakes with the ADC macro.
module adc_timeout_cnt #(
   parameter logic [7:0] TERM = 8'd255
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_term
);

   logic [7:0] r_count;

   // count register: clear wins over enable, holds at the terminal value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= 8'd0;
      end else if (i_clr) begin
         r_count <= 8'd0;
      end else if (i_en && (r_count != TERM)) begin
         r_count <= r_count + 8'd1;
      end else begin
         r_count <= r_count;
      end
   end

   assign o_term = (r_count == TERM);

endmodule

// File: rtl/adc_conv_scheduler.sv
// Single-clock scheduler for the shared ADC macro: I, Q and a decimated MIC
// conversion, delivering time-aligned I/Q pairs and MIC samples.
module adc_conv_scheduler
   import adc_conv_scheduler_pkg::*;
#(
   parameter int unsigned MIC_DIV = 4,
   parameter logic [7:0]  TIMEOUT = 8'd255
) (
   input  logic        ADC_CLK,
   input  logic        RST,
   input  logic        en,
   input  logic        adc_eoc,
   input  logic [11:0] adc_dout,
   output logic [2:0]  adc_s,
   output logic        adc_soc,
   output logic [11:0] msi_i,
   output logic [11:0] msi_q,
   output logic        iq_valid,
   output logic [11:0] mic_data,
   output logic        mic_valid,
   output logic        timeout_err
);

   localparam logic [3:0] MIC_LAST = 4'(MIC_DIV - 1);

   state_t      r_state;
   state_t      w_next;
   slot_t       r_slot;
   logic [3:0]  r_pair;
   logic [11:0] r_hold;
   logic [11:0] r_cap;
   logic [11:0] r_msi_i;
   logic [11:0] r_msi_q;
   logic [11:0] r_mic;
   logic [2:0]  r_adc_s;
   logic        r_soc;
   logic        r_eoc_prev;
   logic        r_iq_valid;
   logic        r_mic_valid;
   logic        r_timeout_err;
   logic        w_eoc_rise;
   logic        w_go;
   logic        w_term;
   logic        w_timeout;

   assign w_eoc_rise = adc_eoc & ~r_eoc_prev;
   // a Q slot is forced so an I/Q pair is never split by en going low
   assign w_go       = en | (r_slot == SLOT_Q);
   assign w_timeout  = (r_state == S_WAIT) & ~w_eoc_rise & w_term;

   adc_timeout_cnt #(.TERM(TIMEOUT)) u_timeout_cnt (
      .clk    (ADC_CLK),
      .rst    (RST),
      .i_clr  (r_state == S_START),
      .i_en   (r_state == S_WAIT),
      .o_term (w_term)
   );

   // FSM state register
   always_ff @(posedge ADC_CLK or posedge RST) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_go) begin
               w_next = S_START;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_START: w_next = S_WAIT;
         S_WAIT: begin
            if (w_eoc_rise) begin
               w_next = S_STORE;
            end else if (w_term) begin
               w_next = S_IDLE;
            end else begin
               w_next = S_WAIT;
            end
         end
         S_STORE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // datapath: channel select, capture, per-slot commit and slot sequencing
   always_ff @(posedge ADC_CLK or posedge RST) begin
      if (RST) begin
         r_slot        <= SLOT_I;
         r_pair        <= 4'd0;
         r_hold        <= 12'd0;
         r_cap         <= 12'd0;
         r_msi_i       <= 12'd0;
         r_msi_q       <= 12'd0;
         r_mic         <= 12'd0;
         r_adc_s       <= CH_I;
         r_soc         <= 1'b0;
         r_eoc_prev    <= 1'b0;
         r_iq_valid    <= 1'b0;
         r_mic_valid   <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_eoc_prev  <= adc_eoc;
         r_soc       <= (w_next == S_START);
         r_iq_valid  <= 1'b0;
         r_mic_valid <= 1'b0;
         if ((r_state == S_IDLE) && w_go) begin
            r_adc_s <= slot_to_ch(r_slot);
         end
         if ((r_state == S_WAIT) && w_eoc_rise) begin
            r_cap <= adc_dout;
         end
         if (w_timeout) begin
            r_timeout_err <= 1'b1;
            r_hold        <= 12'd0;
            r_slot        <= SLOT_I;
         end
         if (r_state == S_STORE) begin
            case (r_slot)
               SLOT_I: begin
                  r_hold <= r_cap;
                  r_slot <= SLOT_Q;
               end
               SLOT_Q: begin
                  r_msi_q    <= r_cap;
                  r_msi_i    <= r_hold;
                  r_iq_valid <= 1'b1;
                  if (r_pair == MIC_LAST) begin
                     r_pair <= 4'd0;
                     r_slot <= SLOT_MIC;
                  end else begin
                     r_pair <= r_pair + 4'd1;
                     r_slot <= SLOT_I;
                  end
               end
               SLOT_MIC: begin
                  r_mic       <= r_cap;
                  r_mic_valid <= 1'b1;
                  r_slot      <= SLOT_I;
               end
               default: r_slot <= SLOT_I;
            endcase
         end
      end
   end

   assign adc_s       = r_adc_s;
   assign adc_soc     = r_soc;
   assign msi_i       = r_msi_i;
   assign msi_q       = r_msi_q;
   assign iq_valid    = r_iq_valid;
   assign mic_data    = r_mic;
   assign mic_valid   = r_mic_valid;
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Scoreboard bench for adc_conv_scheduler: an ADC macro model plus directed
// scenarios; a monitor checks every soc channel and every valid pulse.
module tb_adc_conv_scheduler;

   localparam logic [2:0] E_CH_I   = 3'b110;
   localparam logic [2:0] E_CH_Q   = 3'b100;
   localparam logic [2:0] E_CH_MIC = 3'b011;

   typedef struct {
      bit          is_mic;
      logic [11:0] a;
      logic [11:0] b;
   } exp_t;

   logic        ADC_CLK = 1'b0;
   logic        RST = 1'b1;
   logic        en = 1'b0;
   logic        adc_eoc;
   logic [11:0] adc_dout;
   logic [2:0]  adc_s;
   logic        adc_soc;
   logic [11:0] msi_i, msi_q, mic_data;
   logic        iq_valid, mic_valid, timeout_err;

   logic        model_en = 1'b1;
   logic        model_busy = 1'b0;
   logic        withhold_q = 1'b0;
   logic        m_eoc = 1'b0, h_eoc = 1'b0;
   logic [11:0] m_dout = 12'h000, h_dout = 12'h000;
   logic [11:0] i_val = 12'h123, q_val = 12'hABC, mic_val = 12'h7FF;

   exp_t        exp_q[$];
   logic [2:0]  exp_ch[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   assign adc_eoc  = model_en ? m_eoc  : h_eoc;
   assign adc_dout = model_en ? m_dout : h_dout;

   adc_conv_scheduler dut (
      .ADC_CLK     (ADC_CLK),
      .RST         (RST),
      .en          (en),
      .adc_eoc     (adc_eoc),
      .adc_dout    (adc_dout),
      .adc_s       (adc_s),
      .adc_soc     (adc_soc),
      .msi_i       (msi_i),
      .msi_q       (msi_q),
      .iq_valid    (iq_valid),
      .mic_data    (mic_data),
      .mic_valid   (mic_valid),
      .timeout_err (timeout_err)
   );

   always #5 ADC_CLK = ~ADC_CLK;

   // ADC macro model: eoc 20 cycles after soc, data chosen by channel
   initial begin
      logic [11:0] v;
      forever begin
         @(negedge ADC_CLK);
         if (model_en && adc_soc) begin
            if (withhold_q && (adc_s == E_CH_Q)) begin
               withhold_q = 1'b0;
            end else begin
               v = (adc_s == E_CH_I) ? i_val : (adc_s == E_CH_Q) ? q_val :
                   (adc_s == E_CH_MIC) ? mic_val : 12'hFFF;
               model_busy = 1'b1;
               repeat (19) @(negedge ADC_CLK);
               m_eoc = 1'b1;
               m_dout = v;
               @(negedge ADC_CLK);
               m_eoc = 1'b0;
               m_dout = 12'h000;
               model_busy = 1'b0;
            end
         end
      end
   end

   // monitor: pops expectations for every soc and every valid pulse
   always @(negedge ADC_CLK) begin
      exp_t e;
      logic [2:0] c;
      if (iq_valid || mic_valid) begin
         n_cmp++;
         if (iq_valid && mic_valid) begin
            n_bad++;
            $display("FAIL valid_overlap: iq_valid=1 mic_valid=1, required never both");
         end else if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_pulse: iq=%0b mic=%0b i=%h q=%h mic=%h, required no pulse",
                     iq_valid, mic_valid, msi_i, msi_q, mic_data);
         end else begin
            e = exp_q.pop_front();
            if (e.is_mic != mic_valid) begin
               n_bad++;
               $display("FAIL pulse_kind: got mic=%0b, required mic=%0b", mic_valid, e.is_mic);
            end else if (e.is_mic && (mic_data !== e.a)) begin
               n_bad++;
               $display("FAIL mic_data: got %h, required %h", mic_data, e.a);
            end else if (!e.is_mic && ((msi_i !== e.a) || (msi_q !== e.b))) begin
               n_bad++;
               $display("FAIL iq_pair: got i=%h q=%h, required i=%h q=%h",
                        msi_i, msi_q, e.a, e.b);
            end
         end
      end
      if (adc_soc) begin
         n_cmp++;
         if (exp_ch.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_soc: adc_s=%b, required no soc", adc_s);
         end else begin
            c = exp_ch.pop_front();
            if (adc_s !== c) begin
               n_bad++;
               $display("FAIL soc_channel: got %b, required %b", adc_s, c);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // which: 0 iq_valid, 1 mic_valid, 2 adc_soc, 3 timeout_err, 4 model idle
   task automatic wait_sig(input int which, input int budget, input string name);
      int  k;
      bit  hit;
      k = 0;
      hit = 1'b0;
      while (!hit && (k < budget)) begin
         @(negedge ADC_CLK);
         k++;
         case (which)
            0: hit = iq_valid;
            1: hit = mic_valid;
            2: hit = adc_soc;
            3: hit = timeout_err;
            default: hit = !model_busy;
         endcase
      end
      if (!hit) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: got no event, required one within %0d cycles", name, budget);
      end
   endtask

   task automatic push_iq(input logic [11:0] i, input logic [11:0] q);
      exp_t e;
      e.is_mic = 1'b0;
      e.a = i;
      e.b = q;
      exp_q.push_back(e);
      exp_ch.push_back(E_CH_I);
      exp_ch.push_back(E_CH_Q);
   endtask

   task automatic push_mic(input logic [11:0] m);
      exp_t e;
      e.is_mic = 1'b1;
      e.a = m;
      e.b = 12'h000;
      exp_q.push_back(e);
      exp_ch.push_back(E_CH_MIC);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_adc_s"}, 32'(adc_s), 32'(E_CH_I));
      check({tag, "_soc"}, 32'(adc_soc), 32'd0);
      check({tag, "_msi_i"}, 32'(msi_i), 32'd0);
      check({tag, "_msi_q"}, 32'(msi_q), 32'd0);
      check({tag, "_mic"}, 32'(mic_data), 32'd0);
      check({tag, "_valids"}, {30'd0, iq_valid, mic_valid}, 32'd0);
      check({tag, "_timeout"}, 32'(timeout_err), 32'd0);
   endtask

   initial begin
      int socs;

      // reset values
      repeat (3) @(negedge ADC_CLK);
      check_reset_values("reset");
      RST = 1'b0;
      repeat (2) @(negedge ADC_CLK);

      // eight pairs with MIC after every fourth, then park
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < 4; k++) push_iq(12'h123, 12'hABC);
         push_mic(12'h7FF);
      end
      en = 1'b1;
      wait_sig(1, 1000, "mic_pulse_1");
      wait_sig(1, 1000, "mic_pulse_2");
      en = 1'b0;
      repeat (10) @(negedge ADC_CLK);
      check("queue_after_run", 32'(exp_q.size()), 32'd0);

      // en dropped one cycle after I soc: pair completes, then parks
      push_iq(12'h123, 12'hABC);
      en = 1'b1;
      wait_sig(2, 20, "soc_i_en_drop");
      @(negedge ADC_CLK);
      en = 1'b0;
      wait_sig(0, 200, "iq_after_en_drop");
      socs = 0;
      repeat (100) begin
         @(negedge ADC_CLK);
         if (adc_soc) socs++;
      end
      check("park_no_soc", 32'(socs), 32'd0);

      // Q conversion withheld: timeout, pair discarded, restart from I
      i_val = 12'h456;
      q_val = 12'h789;
      withhold_q = 1'b1;
      exp_ch.push_back(E_CH_I);
      exp_ch.push_back(E_CH_Q);
      push_iq(12'h456, 12'h789);
      en = 1'b1;
      wait_sig(3, 600, "timeout_err_set");
      check("timeout_keep_i", 32'(msi_i), 32'h123);
      check("timeout_keep_q", 32'(msi_q), 32'hABC);
      wait_sig(0, 300, "iq_after_timeout");
      en = 1'b0;
      repeat (10) @(negedge ADC_CLK);
      check("timeout_sticky", 32'(timeout_err), 32'd1);

      // eoc already high across START: only a fresh rising edge captures
      model_en = 1'b0;
      h_eoc = 1'b1;
      h_dout = 12'h111;
      push_iq(12'h321, 12'h654);
      en = 1'b1;
      wait_sig(2, 20, "soc_i_stale");
      @(negedge ADC_CLK);
      en = 1'b0;
      repeat (10) @(negedge ADC_CLK);
      h_eoc = 1'b0;
      h_dout = 12'h000;
      repeat (3) @(negedge ADC_CLK);
      h_eoc = 1'b1;
      h_dout = 12'h321;
      @(negedge ADC_CLK);
      h_eoc = 1'b0;
      h_dout = 12'h000;
      wait_sig(2, 20, "soc_q_stale");
      repeat (5) @(negedge ADC_CLK);
      h_eoc = 1'b1;
      h_dout = 12'h654;
      @(negedge ADC_CLK);
      h_eoc = 1'b0;
      h_dout = 12'h000;
      wait_sig(0, 20, "iq_stale");
      model_en = 1'b1;
      repeat (10) @(negedge ADC_CLK);

      // reset asserted mid-WAIT clears everything at once
      exp_ch.push_back(E_CH_I);
      en = 1'b1;
      wait_sig(2, 20, "soc_before_reset");
      repeat (5) @(negedge ADC_CLK);
      RST = 1'b1;
      en = 1'b0;
      #1;
      check_reset_values("midwait_reset");
      wait_sig(4, 100, "model_idle");
      @(negedge ADC_CLK);
      RST = 1'b0;
      push_iq(12'h456, 12'h789);
      @(negedge ADC_CLK);
      en = 1'b1;
      wait_sig(0, 200, "iq_after_reset");
      en = 1'b0;
      repeat (20) @(negedge ADC_CLK);

      check("pulses_left", 32'(exp_q.size()), 32'd0);
      check("socs_left", 32'(exp_ch.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
